// File: rtl/core_v_mcu_pkg.sv
// Shared register-bus types, address rules and router constants for the peripheral subsystem.
package core_v_mcu_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef struct packed {
        addr_t addr;
        logic  write;
        data_t wdata;
        strb_t wstrb;
        logic  valid;
    } reg_req_t;

    typedef struct packed {
        data_t rdata;
        logic  error;
        logic  ready;
    } reg_rsp_t;

    typedef struct packed {
        logic [31:0] idx;
        addr_t       start_addr;
        addr_t       end_addr;
    } rule_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } router_state_e;

    localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;

    // An index or counter over n values never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_reg_router_addr_decode.sv
// Address decoder: compares an address against a rule table; the last (highest-index) matching rule wins.
module addr_decode #(
    parameter int unsigned NoIndices = 2,
    parameter int unsigned NoRules   = 1,
    parameter type         addr_t    = logic [31:0],
    parameter type         rule_t    = logic,
    parameter int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
    input  addr_t               addr_i,
    input  rule_t               addr_map_i [NoRules],
    output logic [IdxWidth-1:0] idx_o,
    output logic                dec_valid_o,
    output logic                dec_error_o,
    input  logic                en_default_idx_i,
    input  logic [IdxWidth-1:0] default_idx_i
);

    always_comb begin
        idx_o       = en_default_idx_i ? default_idx_i : '0;
        dec_valid_o = 1'b0;
        dec_error_o = !en_default_idx_i;
        for (int unsigned i = 0; i < NoRules; i++) begin
            if ((addr_i >= addr_map_i[i].start_addr) && (addr_i < addr_map_i[i].end_addr)) begin
                dec_valid_o = 1'b1;
                dec_error_o = 1'b0;
                idx_o       = IdxWidth'(addr_map_i[i].idx);
            end
        end
    end

endmodule

// File: rtl/periph_reg_router.sv
// Timeout-protected register-bus router: decodes one upstream request to one slave, registers
// the response, answers unmapped/disabled targets with an error and aborts hung slaves.
module periph_reg_router
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned NumRules      = NumPorts,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [31:0] ErrData       = ERR_DATA,
    parameter int unsigned ErrCntWidth   = 16,
    parameter type         addr_t        = core_v_mcu_pkg::addr_t,
    parameter type         reg_req_t     = core_v_mcu_pkg::reg_req_t,
    parameter type         reg_rsp_t     = core_v_mcu_pkg::reg_rsp_t,
    parameter type         rule_t        = core_v_mcu_pkg::rule_t,
    localparam int unsigned IdxWidth     = idx_width(NumPorts)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  reg_req_t               reg_req_i,
    output reg_rsp_t               reg_rsp_o,
    output reg_req_t               reg_req_o [NumPorts],
    input  reg_rsp_t               reg_rsp_i [NumPorts],
    input  rule_t                  addr_map_i [NumRules],
    input  logic [NumPorts-1:0]    port_en_i,
    input  logic                   timeout_clr_i,
    output logic                   timeout_o,
    output logic [IdxWidth-1:0]    timeout_idx_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam int unsigned TCntWidth = idx_width(TimeoutCycles);
    localparam logic [TCntWidth-1:0] TLast =
        TCntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    router_state_e          state_q;
    reg_req_t               req_q;
    reg_rsp_t               rsp_q;
    logic [IdxWidth-1:0]    sel_q;
    logic [TCntWidth-1:0]   tcnt_q;
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic                   timeout_q;
    logic [IdxWidth-1:0]    timeout_idx_q;

    logic [IdxWidth-1:0]    dec_idx;
    logic                   dec_valid;
    logic                   dec_error;
    logic                   dec_ok;
    reg_rsp_t               rsp_sel;

    addr_decode #(
        .NoIndices (NumPorts),
        .NoRules   (NumRules),
        .addr_t    (addr_t),
        .rule_t    (rule_t),
        .IdxWidth  (IdxWidth)
    ) i_addr_decode (
        .addr_i           (reg_req_i.addr),
        .addr_map_i       (addr_map_i),
        .idx_o            (dec_idx),
        .dec_valid_o      (dec_valid),
        .dec_error_o      (dec_error),
        .en_default_idx_i (1'b0),
        .default_idx_i    ('0)
    );

    // A rule pointing past the last port or at a disabled port is handled like a miss.
    assign dec_ok  = dec_valid && !dec_error && (32'(dec_idx) < NumPorts) && port_en_i[dec_idx];
    assign rsp_sel = reg_rsp_i[sel_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            req_q         <= '0;
            rsp_q         <= '0;
            sel_q         <= '0;
            tcnt_q        <= '0;
            err_cnt_q     <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
        end else begin
            if (timeout_clr_i) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        req_q  <= reg_req_i;
                        tcnt_q <= '0;
                        if (dec_ok) begin
                            sel_q   <= dec_idx;
                            state_q <= ISSUE;
                        end else begin
                            rsp_q.rdata <= ErrData;
                            rsp_q.error <= 1'b1;
                            rsp_q.ready <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    // A ready arriving on the expiry cycle still completes normally.
                    if (rsp_sel.ready) begin
                        rsp_q.rdata <= rsp_sel.rdata;
                        rsp_q.error <= rsp_sel.error;
                        rsp_q.ready <= 1'b1;
                        state_q     <= RESP;
                    end else if ((TimeoutCycles != 0) && (tcnt_q == TLast)) begin
                        rsp_q.rdata   <= ErrData;
                        rsp_q.error   <= 1'b1;
                        rsp_q.ready   <= 1'b1;
                        timeout_q     <= 1'b1;
                        timeout_idx_q <= sel_q;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                        state_q <= RESP;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            reg_req_o[i] = '0;
            if ((state_q == ISSUE) && (sel_q == IdxWidth'(i))) begin
                reg_req_o[i] = req_q;
            end
        end
    end

    assign reg_rsp_o     = rsp_q;
    assign timeout_o     = timeout_q;
    assign timeout_idx_o = timeout_idx_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_periph_reg_router.sv
// Self-checking bench for periph_reg_router: behavioural slaves, scoreboard of expected responses.
module tb_periph_reg_router;
    import core_v_mcu_pkg::*;

    localparam int NP  = 4;
    localparam int TO  = 8;
    localparam int ECW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    reg_req_t       req;
    reg_rsp_t       rsp;
    reg_req_t       sreq [NP];
    reg_rsp_t       srsp [NP];
    rule_t          amap [NP];
    logic [NP-1:0]  port_en;
    logic           tclr;
    logic           tout;
    logic [1:0]     tidx;
    logic [ECW-1:0] ecnt;

    int          swait [NP];
    logic [31:0] sdata [NP];
    logic        serr  [NP];
    int          scnt  [NP];

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          lat;
        int          port;
        int          vcycles;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    periph_reg_router #(
        .NumPorts      (NP),
        .NumRules      (NP),
        .TimeoutCycles (TO),
        .ErrData       (32'hBADCAB1E),
        .ErrCntWidth   (ECW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .reg_req_i     (req),
        .reg_rsp_o     (rsp),
        .reg_req_o     (sreq),
        .reg_rsp_i     (srsp),
        .addr_map_i    (amap),
        .port_en_i     (port_en),
        .timeout_clr_i (tclr),
        .timeout_o     (tout),
        .timeout_idx_o (tidx),
        .err_cnt_o     (ecnt)
    );

    // Each slave answers after swait[p] wait cycles of a held valid.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            srsp[p].ready = sreq[p].valid && (scnt[p] == swait[p]);
            srsp[p].rdata = sdata[p];
            srsp[p].error = serr[p];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int p = 0; p < NP; p++) begin
            if (!rst_n) scnt[p] <= 0;
            else if (sreq[p].valid && !srsp[p].ready) scnt[p] <= scnt[p] + 1;
            else scnt[p] <= 0;
        end
    end

    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input bit hold, input logic [31:0] exp_rdata, input logic exp_err,
                           input int lat, input int port, input int vcycles);
        exp_t e;
        int   vc [NP];
        int   first_v;
        bit   done;
        e.rdata = exp_rdata; e.error = exp_err; e.lat = lat; e.port = port; e.vcycles = vcycles;
        sb.push_back(e);
        req.addr = addr; req.write = wr; req.wdata = wdata; req.wstrb = 4'hF; req.valid = 1'b1;
        for (int p = 0; p < NP; p++) vc[p] = 0;
        first_v = -1;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (sreq[p].valid) begin
                    if (vc[p] == 0 && p == port) begin
                        first_v = c;
                        checks++;
                        if (sreq[p].addr !== addr || sreq[p].wdata !== wdata || sreq[p].write !== wr) begin
                            errors++;
                            $display("[TB] FAIL slave_payload port%0d: got addr=%h wdata=%h wr=%b, expected addr=%h wdata=%h wr=%b",
                                     p, sreq[p].addr, sreq[p].wdata, sreq[p].write, addr, wdata, wr);
                        end
                    end
                    vc[p]++;
                end
            end
            if (rsp.ready) begin
                e = sb.pop_front();
                done = 1;
                checks++;
                if (rsp.rdata !== e.rdata) begin
                    errors++;
                    $display("[TB] FAIL rdata @%h: got %h expected %h", addr, rsp.rdata, e.rdata);
                end
                checks++;
                if (rsp.error !== e.error) begin
                    errors++;
                    $display("[TB] FAIL error @%h: got %b expected %b", addr, rsp.error, e.error);
                end
                checks++;
                if (c != e.lat) begin
                    errors++;
                    $display("[TB] FAIL latency @%h: got %0d expected %0d", addr, c, e.lat);
                end
                for (int p = 0; p < NP; p++) begin
                    checks++;
                    if (vc[p] != ((p == e.port) ? e.vcycles : 0)) begin
                        errors++;
                        $display("[TB] FAIL slave_valid_cycles port%0d: got %0d expected %0d",
                                 p, vc[p], (p == e.port) ? e.vcycles : 0);
                    end
                end
                if (e.port >= 0) begin
                    checks++;
                    if (first_v != 1) begin
                        errors++;
                        $display("[TB] FAIL slave_first_valid_cycle: got %0d expected 1", first_v);
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL no_response @%h: got none within 40 cycles, expected ready", addr);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        if (!hold) req.valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic exp_tout, input logic [1:0] exp_tidx,
                                input logic [ECW-1:0] exp_ecnt);
        checks++;
        if (tout !== exp_tout) begin
            errors++;
            $display("[TB] FAIL %s timeout_o: got %b expected %b", name, tout, exp_tout);
        end
        checks++;
        if (tidx !== exp_tidx) begin
            errors++;
            $display("[TB] FAIL %s timeout_idx_o: got %0d expected %0d", name, tidx, exp_tidx);
        end
        checks++;
        if (ecnt !== exp_ecnt) begin
            errors++;
            $display("[TB] FAIL %s err_cnt_o: got %0d expected %0d", name, ecnt, exp_ecnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (rsp !== '0) begin
            errors++;
            $display("[TB] FAIL %s reg_rsp_o: got %h expected 0", name, rsp);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (sreq[p] !== '0) begin
                errors++;
                $display("[TB] FAIL %s reg_req_o[%0d]: got %h expected 0", name, p, sreq[p]);
            end
        end
        check_status(name, 1'b0, 2'd0, '0);
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("after_reset");
    endtask

    task automatic test_write_zero_wait();
        swait[2] = 0; sdata[2] = 32'h0;
        run_txn(32'h0000_2010, 1'b1, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 2, 2, 1);
        check_status("write", 1'b0, 2'd0, 2'd0);
    endtask

    task automatic test_read_wait();
        swait[1] = 3; sdata[1] = 32'h1234_5678;
        run_txn(32'h0000_1004, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, 5, 1, 4);
    endtask

    task automatic test_slave_error();
        swait[2] = 1; sdata[2] = 32'hDEAD_0001; serr[2] = 1'b1;
        run_txn(32'h0000_2000, 1'b0, 32'h0, 0, 32'hDEAD_0001, 1'b1, 3, 2, 2);
        serr[2] = 1'b0;
        check_status("slave_error", 1'b0, 2'd0, 2'd0);
    endtask

    task automatic test_decode_error();
        run_txn(32'h0000_8000, 1'b0, 32'h0, 0, 32'hBADCAB1E, 1'b1, 1, -1, 0);
        check_status("unmapped", 1'b0, 2'd0, 2'd1);
        port_en[1] = 1'b0;
        run_txn(32'h0000_1000, 1'b1, 32'h55, 0, 32'hBADCAB1E, 1'b1, 1, -1, 0);
        port_en[1] = 1'b1;
        check_status("disabled", 1'b0, 2'd0, 2'd2);
    endtask

    task automatic test_timeout();
        swait[3] = 1000;
        run_txn(32'h0000_3000, 1'b0, 32'h0, 0, 32'hBADCAB1E, 1'b1, TO + 1, 3, TO);
        check_status("timeout", 1'b1, 2'd3, 2'd3);
        tclr = 1'b1;
        @(posedge clk); #1;
        tclr = 1'b0;
        check_status("timeout_clr", 1'b0, 2'd3, 2'd3);
    endtask

    task automatic test_expiry_ready();
        swait[0] = TO - 1; sdata[0] = 32'hA5A5_0000;
        run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'hA5A5_0000, 1'b0, TO + 1, 0, TO);
        check_status("expiry_ready", 1'b0, 2'd3, 2'd3);
    endtask

    task automatic test_saturation();
        run_txn(32'h0001_0000, 1'b0, 32'h0, 0, 32'hBADCAB1E, 1'b1, 1, -1, 0);
        check_status("sat4", 1'b0, 2'd3, 2'd3);
        run_txn(32'hFFFF_FFF0, 1'b0, 32'h0, 0, 32'hBADCAB1E, 1'b1, 1, -1, 0);
        check_status("sat5", 1'b0, 2'd3, 2'd3);
    endtask

    task automatic test_overlap();
        amap[3].start_addr = 32'h2000;
        swait[3] = 0; sdata[3] = 32'h0000_0033;
        run_txn(32'h0000_2800, 1'b0, 32'h0, 0, 32'h0000_0033, 1'b0, 2, 3, 1);
        amap[3].start_addr = 32'h3000;
    endtask

    task automatic test_back_to_back();
        swait[0] = 0; sdata[0] = 32'h0000_00B0;
        swait[1] = 0; sdata[1] = 32'h0000_00B1;
        run_txn(32'h0000_0004, 1'b0, 32'h0, 1, 32'h0000_00B0, 1'b0, 2, 0, 1);
        run_txn(32'h0000_1008, 1'b0, 32'h0, 0, 32'h0000_00B1, 1'b0, 2, 1, 1);
    endtask

    task automatic test_reset_mid();
        swait[1] = 1000;
        req.addr = 32'h0000_1000; req.write = 1'b0; req.wdata = '0; req.wstrb = 4'hF; req.valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (sreq[1].valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_issue: got valid=%b expected 1", sreq[1].valid);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        req.valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        swait[1] = 0; sdata[1] = 32'h0000_0777;
        @(posedge clk); #1;
        run_txn(32'h0000_1000, 1'b0, 32'h0, 0, 32'h0000_0777, 1'b0, 2, 1, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        tclr = 1'b0;
        port_en = '1;
        for (int p = 0; p < NP; p++) begin
            amap[p].idx        = p;
            amap[p].start_addr = 32'h1000 * p;
            amap[p].end_addr   = 32'h1000 * (p + 1);
            swait[p] = 0;
            sdata[p] = '0;
            serr[p]  = 1'b0;
        end
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_error();
        test_decode_error();
        test_timeout();
        test_expiry_ready();
        test_saturation();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/periph_reg_router.md
# periph_reg_router

Timeout-protected register-bus router between the AXI-to-reg converter and the peripheral register slaves. It replaces a plain combinational reg demux. It decodes each request against a runtime address map and forwards it to exactly one of `NumPorts` slaves. It registers the response, answers unmapped or disabled targets with an error, and aborts hung slaves after a programmable number of cycles, keeping sticky status and an error count.

## Interface
Parameters:
- `NumPorts`, 4: number of downstream reg slaves (≥1).
- `NumRules`, `NumPorts`: address-map entries.
- `TimeoutCycles`, 256: cycles a slave may stall before abort; 0 disables the timeout.
- `ErrData`, `32'hBADCAB1E`: `rdata` returned on any error response.
- `ErrCntWidth`, 16: width of the error counter.
- `addr_t`, `reg_req_t`, `reg_rsp_t`, `rule_t`: bus and rule types (`rule_t` = {idx, start_addr, end_addr}).

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `reg_req_i` in `reg_req_t`: upstream request.
- `reg_rsp_o` out `reg_rsp_t`: upstream response.
- `reg_req_o` out `NumPorts`×`reg_req_t`: per-slave requests.
- `reg_rsp_i` in `NumPorts`×`reg_rsp_t`: per-slave responses.
- `addr_map_i` in `NumRules`×`rule_t`: address rules, with `end_addr` exclusive.
- `port_en_i` in `NumPorts`: per-port enable; a disabled port is treated as unmapped.
- `timeout_clr_i` in 1: clears the sticky timeout status.
- `timeout_o` out 1: sticky flag, set on a slave abort.
- `timeout_idx_o` out `max(1,$clog2(NumPorts))`: port that timed out most recently.
- `err_cnt_o` out `ErrCntWidth`: saturating count of decode errors plus timeouts.

## Operation
FSM states are IDLE, ISSUE and RESP.
- **IDLE:** on `reg_req_i.valid`, latch addr, write, wdata and wstrb.
  - Decode: the highest-index matching rule wins.
  - Hit on an enabled port: latch `sel` and go to ISSUE.
  - Miss or disabled port: load the error response (`error`=1, `rdata`=`ErrData`), increment the error counter, and go to RESP.
- **ISSUE:**
  - Drive `reg_req_o[sel]` from the latched fields with `valid`=1. All other ports keep `valid`=0; their payload fields are don't-care but are driven 0.
  - On `reg_rsp_i[sel].ready`: capture `rdata` and `error`, then go to RESP.
  - Timeout: the counter increments each ISSUE cycle without ready. If it reaches `TimeoutCycles`-1 with no ready, drop `valid`, load the error response, set `timeout_o`, load `timeout_idx_o`=`sel`, increment the error counter, and go to RESP.
- **RESP:** `reg_rsp_o.ready`=1 for exactly one cycle with the captured `rdata` and `error`, then go to IDLE.
- Outside RESP, `reg_rsp_o` is all-zero.
- Upstream holds `valid` and payload until it sees ready; the router ignores upstream changes after the IDLE capture.
- The error counter saturates at all-ones.
- Slave-reported errors (`error`=1 with ready) pass through unchanged and are not counted.

## Timing
- **Reset values:** state IDLE; all `reg_req_o`=0; `reg_rsp_o`=0; `timeout_o`=0; `timeout_idx_o`=0; `err_cnt_o`=0; timeout counter 0.
- **Mapped access latency:** valid seen in cycle 0, slave valid in cycle 1. A zero-wait slave gives upstream ready in cycle 2. Each slave wait cycle adds one.
- **Decode error latency:** upstream ready in cycle 1.
- **Timeout:**
  - With `TimeoutCycles`=N, slave valid is high for exactly N cycles, and upstream sees the error response in cycle N+1.
  - Slave ready in the same cycle as expiry: ready wins and the response is normal.
- **Back-to-back requests:** a request held after the RESP cycle is accepted as a new transaction in the following IDLE cycle. Throughput is at most one request per 3 cycles.
- **Simultaneous timeout set and `timeout_clr_i`:** set wins.
- **Runtime changes:** `addr_map_i` and `port_en_i` are sampled only in IDLE; changes mid-transaction do not affect it.
- **Reset mid-transaction:** everything returns to reset values immediately and asynchronously; no response is issued.

## Structure
- State enum `router_state_e` and the default `ErrData` constant go in `core_v_mcu_pkg`, next to `reg_req_t`, `reg_rsp_t` and `rule_t`.
- Decode instantiates the common-cells `addr_decode` with `en_default_idx_i`=0, using `dec_error_o` as the miss indicator.
- The FSM, counters and output mux are implemented locally; no further sub-module.
- `NumPorts`=1 forces an index width of 1.

## Test plan
- Write to port 2 with a zero-wait slave → `reg_req_o[2].valid` in cycle 1 only, upstream ready in cycle 2, `error`=0, other ports idle.
- Read from port 1 with a slave 3 wait cycles, `rdata`=`32'h1234_5678` → upstream ready in cycle 5 with that data.
- Address outside all rules, then an access to a port with `port_en_i` bit cleared → ready in cycle 1 with `error`=1 and `rdata`=`BADCAB1E`; `err_cnt_o` increments 0→1→2; no slave valid.
- Slave never readies, `TimeoutCycles`=8 → slave valid for 8 cycles, error in cycle 9, `timeout_o`=1, `timeout_idx_o`=port. Then assert `timeout_clr_i` → flag clears.
- Slave ready exactly on the expiry cycle → normal response, `timeout_o` remains 0; `ErrCntWidth`=2 with 5 errors → `err_cnt_o` saturates at 3.
- Assert `rst_ni` low during ISSUE → all outputs return to 0 asynchronously; the next request after reset completes normally.
